// File: rtl/ysyx_210184_wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_210184_wb_pipe_pkg
// Shared definitions for the write-back pipeline slice: the default register
// bus width, the load size / sign encodings carried on load_bytes, the FSM
// state encoding and the byte-offset width derivation.
// No ports (package).
// ---------------------------------------------------------------------------
package ysyx_210184_wb_pipe_pkg;

    // Default architectural register width.
    localparam int REG_BUS = 64;

    // load_bytes[1:0] size field.
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } load_size_e;

    // load_bytes[2]: 1 selects zero-fill, 0 selects sign extension.
    localparam int LOAD_UNSIGNED_BIT = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } wb_state_e;

    // Width of the byte offset inside one XLEN-wide memory beat.
    function automatic int offw_of(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/ysyx_210184_wb_pipe_if.sv
// ---------------------------------------------------------------------------
// ysyx_210184_wb_pipe_if
// Bundles the MEM-stage to write-back signals.
//   master : MEM stage side (drives instruction, memory beats, flush)
//   slave  : write-back block side (drives in_ready, result, strobe, busy)
// Parameters: XLEN register width, RIDX register-index width.
// ---------------------------------------------------------------------------
interface ysyx_210184_wb_pipe_if #(
    parameter int XLEN = 64,
    parameter int RIDX = 5
);
    import ysyx_210184_wb_pipe_pkg::*;

    localparam int OFFW = offw_of(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [XLEN-1:0] wb_data;
    logic            beat2_valid;
    logic [XLEN-1:0] wb_data_hi;
    logic [XLEN-1:0] result_ALU;
    logic [XLEN-1:0] pc_plus_4_i;
    logic            load_ena_i;
    logic            is_misalign_i;
    logic [2:0]      load_bytes_i;
    logic [OFFW-1:0] addr_lo_i;
    logic [RIDX-1:0] rd;
    logic            w_rd_ena;
    logic            is_jal_i;
    logic            is_jalr_i;
    logic [XLEN-1:0] wb_data_o;
    logic [RIDX-1:0] rd_o;
    logic            w_ena_o;
    logic            busy_o;

    modport master (
        output in_valid, flush, wb_data, beat2_valid, wb_data_hi, result_ALU,
               pc_plus_4_i, load_ena_i, is_misalign_i, load_bytes_i, addr_lo_i,
               rd, w_rd_ena, is_jal_i, is_jalr_i,
        input  in_ready, wb_data_o, rd_o, w_ena_o, busy_o
    );

    modport slave (
        input  in_valid, flush, wb_data, beat2_valid, wb_data_hi, result_ALU,
               pc_plus_4_i, load_ena_i, is_misalign_i, load_bytes_i, addr_lo_i,
               rd, w_rd_ena, is_jal_i, is_jalr_i,
        output in_ready, wb_data_o, rd_o, w_ena_o, busy_o
    );

endinterface

// File: rtl/ysyx_210184_wb_pipe_load_align.sv
// ---------------------------------------------------------------------------
// ysyx_210184_load_align
// Combinational load alignment and extension.
//   src_lo     in  XLEN  low memory beat
//   src_hi     in  XLEN  high memory beat (zero for single-beat loads)
//   addr_lo    in  OFFW  byte offset of the load inside the low beat
//   load_bytes in  3     [1:0] size, [2] unsigned
//   load_val   out XLEN  aligned, sized and extended load value
// ---------------------------------------------------------------------------
module ysyx_210184_load_align
    import ysyx_210184_wb_pipe_pkg::*;
#(
    parameter  int XLEN = REG_BUS,
    localparam int OFFW = offw_of(XLEN)
) (
    input  logic [XLEN-1:0] src_lo,
    input  logic [XLEN-1:0] src_hi,
    input  logic [OFFW-1:0] addr_lo,
    input  logic [2:0]      load_bytes,
    output logic [XLEN-1:0] load_val
);

    logic [2*XLEN-1:0] src;
    logic [OFFW+2:0]   shamt;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   keep_mask;
    logic              sign_bit;
    logic              fill;
    load_size_e        size;

    // Two-beat window shifted down by the byte offset; only the low XLEN
    // bits can ever belong to the loaded value.
    assign src   = {src_hi, src_lo};
    assign shamt = {addr_lo, 3'b000};
    assign raw   = XLEN'(src >> shamt);

    always_comb begin
        size      = load_size_e'(load_bytes[1:0]);
        keep_mask = '1;
        sign_bit  = raw[XLEN-1];

        // A 32-bit core has no doubleword; a D load behaves as a W load.
        if (XLEN == 32 && size == SIZE_D) begin
            size = SIZE_W;
        end

        case (size)
            SIZE_B: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = raw[7];
            end
            SIZE_H: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = raw[15];
            end
            SIZE_W: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = raw[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = raw[XLEN-1];
            end
        endcase

        fill     = ~load_bytes[LOAD_UNSIGNED_BIT] & sign_bit;
        load_val = (raw & keep_mask) | (fill ? ~keep_mask : '0);
    end

endmodule

// File: rtl/ysyx_210184_wb_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_210184_wb_pipe
// Write-back stage: selects the write-back value (link, load or ALU result),
// merges loads that straddle two memory beats, and registers the register
// file write (one-cycle strobe).
//   clk  in  1  clock, rising edge
//   rst  in  1  asynchronous active-low reset
//   bus  slave modport of ysyx_210184_wb_pipe_if (handshake, operands,
//        memory beats, flush, registered results, busy)
// ---------------------------------------------------------------------------
module ysyx_210184_wb_pipe
    import ysyx_210184_wb_pipe_pkg::*;
#(
    parameter int XLEN = REG_BUS,
    parameter int RIDX = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_210184_wb_pipe_if.slave  bus
);

    localparam int OFFW = offw_of(XLEN);

    wb_state_e       state_q, state_d;
    logic [XLEN-1:0] lo_beat_q, lo_beat_d;
    logic [2:0]      bytes_q, bytes_d;
    logic [OFFW-1:0] addr_q, addr_d;
    logic [RIDX-1:0] rd_cap_q, rd_cap_d;
    logic            wrd_cap_q, wrd_cap_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [RIDX-1:0] rd_q, rd_d;
    logic            w_ena_q, w_ena_d;

    logic            merging;
    logic [XLEN-1:0] align_lo;
    logic [XLEN-1:0] align_hi;
    logic [OFFW-1:0] align_addr;
    logic [2:0]      align_bytes;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] idle_result;

    assign merging = (state_q == ST_MERGE);

    // The aligner sees the live instruction in IDLE and the captured low beat
    // plus the arriving high beat while merging.
    always_comb begin
        align_lo    = bus.wb_data;
        align_hi    = '0;
        align_addr  = bus.addr_lo_i;
        align_bytes = bus.load_bytes_i;
        if (merging) begin
            align_lo    = lo_beat_q;
            align_hi    = bus.wb_data_hi;
            align_addr  = addr_q;
            align_bytes = bytes_q;
        end
    end

    ysyx_210184_load_align #(.XLEN(XLEN)) u_load_align (
        .src_lo     (align_lo),
        .src_hi     (align_hi),
        .addr_lo    (align_addr),
        .load_bytes (align_bytes),
        .load_val   (load_val)
    );

    // Jumps write the link value even if decode also flagged a load.
    always_comb begin
        idle_result = bus.result_ALU;
        if (bus.is_jal_i || bus.is_jalr_i) begin
            idle_result = bus.pc_plus_4_i;
        end else if (bus.load_ena_i) begin
            idle_result = load_val;
        end
    end

    // Result registers only move when a write is actually issued, so they
    // keep the last written value otherwise. Flush wins over everything.
    always_comb begin
        state_d   = state_q;
        lo_beat_d = lo_beat_q;
        bytes_d   = bytes_q;
        addr_d    = addr_q;
        rd_cap_d  = rd_cap_q;
        wrd_cap_d = wrd_cap_q;
        wb_data_d = wb_data_q;
        rd_d      = rd_q;
        w_ena_d   = 1'b0;

        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.load_ena_i && bus.is_misalign_i) begin
                            lo_beat_d = bus.wb_data;
                            bytes_d   = bus.load_bytes_i;
                            addr_d    = bus.addr_lo_i;
                            rd_cap_d  = bus.rd;
                            wrd_cap_d = bus.w_rd_ena;
                            state_d   = ST_MERGE;
                        end else if (bus.w_rd_ena && (bus.rd != '0)) begin
                            w_ena_d   = 1'b1;
                            wb_data_d = idle_result;
                            rd_d      = bus.rd;
                        end
                    end
                end
                ST_MERGE: begin
                    if (bus.beat2_valid) begin
                        state_d = ST_IDLE;
                        if (wrd_cap_q && (rd_cap_q != '0)) begin
                            w_ena_d   = 1'b1;
                            wb_data_d = load_val;
                            rd_d      = rd_cap_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, captured merge context and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lo_beat_q <= '0;
            bytes_q   <= '0;
            addr_q    <= '0;
            rd_cap_q  <= '0;
            wrd_cap_q <= 1'b0;
            wb_data_q <= '0;
            rd_q      <= '0;
            w_ena_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_beat_q <= lo_beat_d;
            bytes_q   <= bytes_d;
            addr_q    <= addr_d;
            rd_cap_q  <= rd_cap_d;
            wrd_cap_q <= wrd_cap_d;
            wb_data_q <= wb_data_d;
            rd_q      <= rd_d;
            w_ena_q   <= w_ena_d;
        end
    end

    assign bus.in_ready  = ~merging;
    assign bus.busy_o    = merging;
    assign bus.wb_data_o = wb_data_q;
    assign bus.rd_o      = rd_q;
    assign bus.w_ena_o   = w_ena_q;

endmodule

// File: tb/tb_ysyx_210184_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_ysyx_210184_wb_pipe
// Directed self-checking bench for ysyx_210184_wb_pipe: a 64-bit instance
// covers ALU, loads, the two-beat merge, jumps, flush and reset; a 32-bit
// instance covers the doubleword-as-word case.
// ---------------------------------------------------------------------------
module tb_ysyx_210184_wb_pipe;

    logic clk;
    logic rst_n;
    int   check_count;
    int   pass_count;

    ysyx_210184_wb_pipe_if #(.XLEN(64), .RIDX(5)) bus64 ();
    ysyx_210184_wb_pipe_if #(.XLEN(32), .RIDX(5)) bus32 ();

    ysyx_210184_wb_pipe #(.XLEN(64), .RIDX(5)) dut64 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus64)
    );

    ysyx_210184_wb_pipe #(.XLEN(32), .RIDX(5)) dut32 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus32)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    // Presents one instruction to the 64-bit instance for one cycle; returns
    // just after the capturing edge so registered outputs can be sampled.
    task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] pc4,
                                 input logic [63:0] wbd, input logic ld,
                                 input logic mis, input logic jal, input logic jalr,
                                 input logic [2:0] bytes, input logic [2:0] addr,
                                 input logic [4:0] rd, input logic wrd);
        @(negedge clk);
        bus64.result_ALU    = alu;
        bus64.pc_plus_4_i   = pc4;
        bus64.wb_data       = wbd;
        bus64.load_ena_i    = ld;
        bus64.is_misalign_i = mis;
        bus64.is_jal_i      = jal;
        bus64.is_jalr_i     = jalr;
        bus64.load_bytes_i  = bytes;
        bus64.addr_lo_i     = addr;
        bus64.rd            = rd;
        bus64.w_rd_ena      = wrd;
        bus64.in_valid      = 1'b1;
        @(posedge clk);
        #1;
        bus64.in_valid      = 1'b0;
        bus64.load_ena_i    = 1'b0;
        bus64.is_misalign_i = 1'b0;
        bus64.is_jal_i      = 1'b0;
        bus64.is_jalr_i     = 1'b0;
    endtask

    // Delivers the second memory beat (optionally with flush) for one cycle.
    task automatic applyBeat2(input logic [63:0] hi, input logic with_flush);
        @(negedge clk);
        bus64.wb_data_hi  = hi;
        bus64.wb_data     = 64'hDEAD_BEEF_DEAD_BEEF;
        bus64.beat2_valid = 1'b1;
        bus64.flush       = with_flush;
        @(posedge clk);
        #1;
        bus64.beat2_valid = 1'b0;
        bus64.flush       = 1'b0;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        bus64.in_valid = 1'b0; bus64.flush = 1'b0; bus64.wb_data = '0;
        bus64.beat2_valid = 1'b0; bus64.wb_data_hi = '0; bus64.result_ALU = '0;
        bus64.pc_plus_4_i = '0; bus64.load_ena_i = 1'b0; bus64.is_misalign_i = 1'b0;
        bus64.load_bytes_i = '0; bus64.addr_lo_i = '0; bus64.rd = '0;
        bus64.w_rd_ena = 1'b0; bus64.is_jal_i = 1'b0; bus64.is_jalr_i = 1'b0;
        bus32.in_valid = 1'b0; bus32.flush = 1'b0; bus32.wb_data = '0;
        bus32.beat2_valid = 1'b0; bus32.wb_data_hi = '0; bus32.result_ALU = '0;
        bus32.pc_plus_4_i = '0; bus32.load_ena_i = 1'b0; bus32.is_misalign_i = 1'b0;
        bus32.load_bytes_i = '0; bus32.addr_lo_i = '0; bus32.rd = '0;
        bus32.w_rd_ena = 1'b0; bus32.is_jal_i = 1'b0; bus32.is_jalr_i = 1'b0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_w_ena",    bus64.w_ena_o,   1'b0);
        checkOutput("reset_wb_data",  bus64.wb_data_o, 64'h0);
        checkOutput("reset_rd_o",     bus64.rd_o,      5'd0);
        checkOutput("reset_busy",     bus64.busy_o,    1'b0);
        checkOutput("reset_in_ready", bus64.in_ready,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result, one-cycle strobe, then hold.
        applyStimulus(64'h1234, 64'h0, 64'h0, 0, 0, 0, 0, 3'b000, 3'd0, 5'd5, 1);
        checkOutput("alu_w_ena",   bus64.w_ena_o,   1'b1);
        checkOutput("alu_rd_o",    bus64.rd_o,      5'd5);
        checkOutput("alu_wb_data", bus64.wb_data_o, 64'h1234);
        @(posedge clk); #1;
        checkOutput("alu_pulse_end", bus64.w_ena_o,   1'b0);
        checkOutput("alu_hold",      bus64.wb_data_o, 64'h1234);

        // Aligned LB / LBU at byte offset 1.
        applyStimulus(64'hAAAA, 64'h0, 64'h80FF, 1, 0, 0, 0, 3'b000, 3'd1, 5'd6, 1);
        checkOutput("lb_signed", bus64.wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_rd_o",   bus64.rd_o,      5'd6);
        applyStimulus(64'hAAAA, 64'h0, 64'h80FF, 1, 0, 0, 0, 3'b100, 3'd1, 5'd6, 1);
        checkOutput("lbu_zero", bus64.wb_data_o, 64'h80);

        // Misaligned LW spanning two beats.
        applyStimulus(64'h0, 64'h0, 64'hBBAA_0000_0000_0000, 1, 1, 0, 0, 3'b010, 3'd6, 5'd7, 1);
        checkOutput("merge_accept_no_write", bus64.w_ena_o, 1'b0);
        checkOutput("merge_busy",            bus64.busy_o,  1'b1);
        checkOutput("merge_stall_0",         bus64.in_ready, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            bus64.wb_data = 64'h1111_2222_3333_4444 + 64'(i);
            @(posedge clk); #1;
            checkOutput("merge_stall", bus64.in_ready, 1'b0);
            checkOutput("merge_no_write", bus64.w_ena_o, 1'b0);
        end
        applyBeat2(64'h0000_0000_0000_DDCC, 1'b0);
        checkOutput("merge_wb_data",  bus64.wb_data_o, 64'hFFFF_FFFF_DDCC_BBAA);
        checkOutput("merge_rd_o",     bus64.rd_o,      5'd7);
        checkOutput("merge_w_ena",    bus64.w_ena_o,   1'b1);
        checkOutput("merge_done_idle", bus64.busy_o,   1'b0);

        // JALR with load flag still writes the link value.
        applyStimulus(64'h1111, 64'h8000_0008, 64'h2222, 1, 0, 0, 1, 3'b011, 3'd0, 5'd1, 1);
        checkOutput("jalr_wb_data", bus64.wb_data_o, 64'h8000_0008);
        checkOutput("jalr_w_ena",   bus64.w_ena_o,   1'b1);

        // Write to x0 produces no strobe and leaves the outputs alone.
        applyStimulus(64'hDEAD, 64'h0, 64'h0, 0, 0, 0, 0, 3'b000, 3'd0, 5'd0, 1);
        checkOutput("x0_no_write", bus64.w_ena_o,   1'b0);
        checkOutput("x0_hold",     bus64.wb_data_o, 64'h8000_0008);
        checkOutput("x0_rd_hold",  bus64.rd_o,      5'd1);

        // Flush in IDLE suppresses an accepted ALU write.
        bus64.flush = 1'b1;
        applyStimulus(64'h4444, 64'h0, 64'h0, 0, 0, 0, 0, 3'b000, 3'd0, 5'd4, 1);
        bus64.flush = 1'b0;
        checkOutput("flush_idle_no_write", bus64.w_ena_o,   1'b0);
        checkOutput("flush_idle_hold",     bus64.wb_data_o, 64'h8000_0008);

        // Flush overrides beat2 while merging.
        applyStimulus(64'h0, 64'h0, 64'hBBAA_0000_0000_0000, 1, 1, 0, 0, 3'b010, 3'd6, 5'd8, 1);
        checkOutput("flush_merge_busy", bus64.busy_o, 1'b1);
        applyBeat2(64'h0000_0000_0000_DDCC, 1'b1);
        checkOutput("flush_merge_idle",     bus64.busy_o,    1'b0);
        checkOutput("flush_merge_no_write", bus64.w_ena_o,   1'b0);
        checkOutput("flush_merge_hold",     bus64.wb_data_o, 64'h8000_0008);
        applyStimulus(64'h55, 64'h0, 64'h0, 0, 0, 0, 0, 3'b000, 3'd0, 5'd9, 1);
        checkOutput("after_flush_w_ena", bus64.w_ena_o,   1'b1);
        checkOutput("after_flush_data",  bus64.wb_data_o, 64'h55);

        // Asynchronous reset abandons a merge.
        applyStimulus(64'h0, 64'h0, 64'hBBAA_0000_0000_0000, 1, 1, 0, 0, 3'b010, 3'd6, 5'd10, 1);
        checkOutput("rst_merge_busy", bus64.busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_merge_busy_clr", bus64.busy_o,    1'b0);
        checkOutput("rst_merge_data_clr", bus64.wb_data_o, 64'h0);
        checkOutput("rst_merge_rd_clr",   bus64.rd_o,      5'd0);
        applyBeat2(64'h0000_0000_0000_DDCC, 1'b0);
        checkOutput("rst_merge_no_write", bus64.w_ena_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'h77, 64'h0, 64'h0, 0, 0, 0, 0, 3'b000, 3'd0, 5'd3, 1);
        checkOutput("after_rst_w_ena", bus64.w_ena_o,   1'b1);
        checkOutput("after_rst_data",  bus64.wb_data_o, 64'h77);
        checkOutput("after_rst_rd",    bus64.rd_o,      5'd3);

        // 32-bit build: LD behaves as LW; LH sign-extends.
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.load_ena_i = 1'b1; bus32.load_bytes_i = 3'b011;
        bus32.addr_lo_i = 2'd0; bus32.wb_data = 32'h8000_0000; bus32.rd = 5'd2;
        bus32.w_rd_ena = 1'b1; bus32.result_ALU = 32'h1;
        @(posedge clk); #1;
        checkOutput("x32_ld_as_lw", {32'h0, bus32.wb_data_o}, 64'h8000_0000);
        checkOutput("x32_ld_w_ena", bus32.w_ena_o, 1'b1);
        @(negedge clk);
        bus32.load_bytes_i = 3'b001; bus32.wb_data = 32'h0001_8001;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        checkOutput("x32_lh_signed", {32'h0, bus32.wb_data_o}, 64'hFFFF_8001);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
